// File: rtl/n_bit_down_counter.sv
// Registered WIDTH-bit down counter with selectable underflow behaviour
// (wrap, saturate or auto-reload), a zero flag and a one-cycle borrow pulse.
module n_bit_down_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned MODE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             borrow_q, borrow_d;

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    borrow_d = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
    end else if (en) begin
      if (count_q != '0) begin
        count_d = count_q - One;
      end else begin
        // Underflow: borrow pulses in every mode, even when reloading zero.
        borrow_d = 1'b1;
        case (MODE)
          1:       count_d = '0;
          2:       count_d = reload_q;
          default: count_d = '1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      borrow_q <= borrow_d;
    end
  end

  assign count  = count_q;
  assign zero   = (count_q == '0);
  assign borrow = borrow_q;

endmodule

// File: tb/tb_n_bit_down_counter.sv
// Scoreboard bench: several counter instances of different WIDTH/MODE share one
// stimulus stream; expected outputs are queued per edge and compared after it.
module tb_n_bit_down_counter;

  localparam int NDut = 7;
  localparam int unsigned DutW [NDut] = '{10, 10, 10, 2, 16, 2, 16};
  localparam int unsigned DutM [NDut] = '{0, 1, 2, 0, 0, 1, 1};

  logic        clk = 1'b0;
  logic        reset, load, en;
  logic [31:0] lv;

  logic [31:0]       cnt_obs [NDut];
  logic [NDut-1:0]   zr_obs, br_obs;

  typedef struct packed {
    logic [NDut-1:0][31:0] cnt;
    logic [NDut-1:0]       zr;
    logic [NDut-1:0]       br;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_cnt [NDut];
  logic [31:0] m_rld [NDut];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    localparam int unsigned GW = DutW[g];
    localparam int unsigned GM = DutM[g];
    logic [GW-1:0] c;
    logic          z, b;
    n_bit_down_counter #(.WIDTH(GW), .MODE(GM)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (lv[GW-1:0]),
      .en         (en),
      .count      (c),
      .zero       (z),
      .borrow     (b)
    );
    assign cnt_obs[g] = 32'(c);
    assign zr_obs[g]  = z;
    assign br_obs[g]  = b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input int unsigned w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  // Drive one edge's inputs, predict every instance, then compare after the edge.
  task automatic cycle(input logic r, input logic l, input logic [31:0] v, input logic e);
    exp_t x;
    logic [31:0] m;
    reset = r; load = l; lv = v; en = e;
    for (int i = 0; i < NDut; i++) begin
      m = mask_of(DutW[i]);
      x.br[i] = 1'b0;
      if (r) begin
        m_cnt[i] = '0; m_rld[i] = '0;
      end else if (l) begin
        m_cnt[i] = v & m; m_rld[i] = v & m;
      end else if (e) begin
        if (m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
        else begin
          x.br[i] = 1'b1;
          if (DutM[i] == 0)      m_cnt[i] = m;
          else if (DutM[i] == 1) m_cnt[i] = '0;
          else                   m_cnt[i] = m_rld[i];
        end
      end
      x.cnt[i] = m_cnt[i];
      x.zr[i]  = (m_cnt[i] == 0);
    end
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    for (int i = 0; i < NDut; i++) begin
      check($sformatf("count[%0d]", i), cnt_obs[i], x.cnt[i]);
      check($sformatf("zero[%0d]", i), 32'(zr_obs[i]), 32'(x.zr[i]));
      check($sformatf("borrow[%0d]", i), 32'(br_obs[i]), 32'(x.br[i]));
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; en = 1'b0; lv = '0;
    for (int i = 0; i < NDut; i++) begin m_cnt[i] = '0; m_rld[i] = '0; end

    // Reset with load and en asserted
    cycle(1, 1, 32'd123, 1);
    cycle(1, 1, 32'd123, 1);
    check("rst_count", cnt_obs[0], 32'd0);
    check("rst_zero", 32'(zr_obs[0]), 32'd1);
    check("rst_borrow", 32'(br_obs[0]), 32'd0);

    // Underflow from 0 straight after reset
    cycle(0, 0, 32'd0, 1);
    check("wrap10", cnt_obs[0], 32'h3FF);
    check("wrap10_borrow", 32'(br_obs[0]), 32'd1);
    check("sat10", cnt_obs[1], 32'd0);
    check("wrap2", cnt_obs[3], 32'd3);
    check("wrap16", cnt_obs[4], 32'hFFFF);
    for (int i = 0; i < 3; i++) cycle(0, 0, 32'd0, 1);
    check("wrap2_end", cnt_obs[3], 32'd0);
    check("wrap10_no_borrow", 32'(br_obs[0]), 32'd0);

    // Load 36 and count down through underflow
    cycle(0, 1, 32'd36, 0);
    for (int i = 0; i < 36; i++) cycle(0, 0, 32'd0, 1);
    check("seq_zero", 32'(zr_obs[0]), 32'd1);
    cycle(0, 0, 32'd0, 1);
    check("seq_wrap", cnt_obs[0], 32'd1023);
    cycle(0, 0, 32'd0, 0);
    check("seq_borrow_once", 32'(br_obs[0]), 32'd0);

    // Saturate and auto-reload patterns
    cycle(0, 1, 32'd1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 32'd0, 1);
    check("sat_borrow", 32'(br_obs[1]), 32'd1);
    cycle(0, 1, 32'd3, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 32'd0, 1);
    check("reload_3", cnt_obs[2], 32'd3);
    cycle(0, 1, 32'd0, 0);
    cycle(0, 0, 32'd0, 1);
    check("reload_0_count", cnt_obs[2], 32'd0);
    check("reload_0_borrow", 32'(br_obs[2]), 32'd1);

    // Load beats en
    cycle(0, 1, 32'd5, 0);
    cycle(0, 1, 32'd1022, 1);
    check("load_wins", cnt_obs[0], 32'd1022);
    cycle(0, 0, 32'd0, 1);
    check("after_load", cnt_obs[0], 32'd1021);
    cycle(0, 1, 32'h3FE, 0);
    cycle(0, 0, 32'd0, 1);
    cycle(0, 0, 32'd0, 1);
    check("after_load2", cnt_obs[0], 32'h3FC);

    // Reset mid-count, then idle hold
    cycle(0, 1, 32'd7, 0);
    cycle(0, 0, 32'd0, 1);
    cycle(1, 1, 32'd9, 1);
    check("mid_reset", cnt_obs[0], 32'd0);
    cycle(0, 0, 32'd0, 0);
    cycle(0, 0, 32'd0, 0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0), $urandom, $urandom_range(0, 1) == 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/n_bit_down_counter.md
# n_bit_down_counter

Parametrised, registered successor to the combinational ten-bit decrementer. It holds a WIDTH-bit count and decrements it by one on each enabled clock. Underflow handling is selectable between wrap, saturate and auto-reload. It reports a zero flag and a one-cycle borrow pulse. It sits in the CPU datapath as the loop/step counter and timer primitive.

## Interface
- WIDTH, 10, count width in bits; legal range 2..32
- MODE, 0, underflow behaviour: 0 = wrap, 1 = saturate, 2 = auto-reload; other values are illegal
- clk  input  1  rising-edge clock; sole clock domain
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk
- load  input  1  load request; loads load_value into count and the reload register
- load_value  input  WIDTH  value captured on load
- en  input  1  decrement enable
- count  output  WIDTH  current registered count
- zero  output  1  high when count == 0; combinational decode of the count register
- borrow  output  1  registered one-cycle pulse, asserted on an enabled decrement from 0

## Operation
- State: count register (WIDTH bits), reload register (WIDTH bits) and borrow register (1 bit).
- Priority on each rising edge: reset > load > en > hold.
- reset: count = 0, reload = 0, borrow = 0.
- load (reset low):
  - count = load_value; reload = load_value; borrow = 0.
  - en is ignored in that cycle.
- en with count != 0: count = count - 1 (modulo 2^WIDTH); borrow = 0.
- en with count == 0: borrow = 1 in every mode; count depends on MODE:
  - MODE 0: count = all ones (2^WIDTH - 1).
  - MODE 1: count stays 0.
  - MODE 2: count = reload. If reload is 0, count stays 0 and borrow still pulses.
- No load and no en: count and reload hold; borrow = 0.
- The reload register changes only on load or reset. Auto-reload never modifies it.
- zero follows count combinationally, so it is valid in the same cycle the count changes.
- Arithmetic is unsigned. No carry or borrow leaves the block except through borrow.

## Timing
- Latency: count, borrow and zero reflect an edge's inputs immediately after that edge (one-cycle register latency). There is no combinational path from inputs to outputs.
- Values after reset: count = 0, zero = 1, borrow = 0.
- borrow is high for exactly one cycle per underflowing edge.
  - Continuous en at count 0 in MODE 1 gives borrow high on every such edge.
  - In MODE 0, borrow is high only on the 0 -> all-ones edge.
- load and en asserted together: load wins, borrow = 0, no decrement.
- reset asserted mid-count: the next edge forces the reset values regardless of load/en. Counting resumes only after reset deasserts and a subsequent load or en.
- Decrement throughput: one per cycle with en held high. No handshake or back-pressure.

## Test plan
- Reset: assert reset for 2 cycles with load = 1 and en = 1 -> count = 0, zero = 1, borrow = 0. Then deassert reset with load = 0 and en = 1 in MODE 0 -> the next edge gives count = 10'h3FF and a borrow pulse.
- Sequence (WIDTH 10, MODE 0): load 36, then en for 36 cycles -> count steps 35..0, zero rises on the 36th edge, borrow = 0 throughout. One more en -> count = 1023 and borrow high for one cycle only.
- Saturate (MODE 1): load 1, then en for 4 cycles -> count = 0, 0, 0, 0. borrow = 0 on the first edge, then 1 on each of the next three edges.
- Auto-reload (MODE 2): load 3, then en for 8 cycles -> count = 2, 1, 0, 3, 2, 1, 0, 3. borrow is high only on the two 0 -> 3 edges. Reload of 0: load 0, then en -> count stays 0 and borrow pulses.
- Simultaneous load and en: count = 5, drive load = 1 with load_value = 1022 and en = 1 -> count = 1022 with no decrement. Then en once -> count = 1021. Then load 10'h3FE and en twice -> 10'h3FD, 10'h3FC.
- Width sweep: repeat the wrap and saturate checks at WIDTH = 2 and WIDTH = 16.
  - WIDTH 2, MODE 0: from 0 with en -> count = 3, then 2, 1, 0.
  - WIDTH 16, MODE 0: underflow -> 16'hFFFF.
